morph_5x5_minmax: RTL and testbench
===================================

# morph_5x5_minmax

Pipelined grey-scale erosion/dilation stage fed directly by the 5x5 window generator. For each accepted window it computes the min (erode) or max (dilate) of the taps selected by a structuring element. It tracks pixel position to emit results only for fully interior windows, and flags row and frame boundaries. Results go to the downstream multiscale combine/writeback logic.

## Interface
- IMG_W, 256, pixels per row (≥5)
- IMG_H, 256, rows per frame (≥5)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  window on `win` corresponds to a newly accepted pixel this cycle
- win  in  200  taps w0..w24 packed, wN at [8N+7:8N]
  - row r = N/5 (0 oldest), col c = N%5; centre is w12
- op  in  1  0 = erode (min), 1 = dilate (max)
- se_sel  in  2  structuring element:
  - 00 square5 (all 25 taps)
  - 01 cross5 (r=2 or c=2, 9 taps)
  - 10 square3 (1≤r,c≤3, 9 taps)
  - 11 diamond (|r-2|+|c-2|≤2, 13 taps)
- out_valid  out  1  out_pix valid
- out_pix  out  8  morphology result
- out_sof  out  1  first output of frame
- out_eol  out  1  last output of a row
- out_eof  out  1  last output of frame

## Operation
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) give the position of the newest pixel (w24). They advance only on in_valid.
  - col wraps to 0 and row increments at col=IMG_W-1.
  - Both wrap to 0 after (IMG_W-1, IMG_H-1).
- A window is interior when row≥4 and col≥4. Only interior windows produce outputs, giving (IMG_W-4)·(IMG_H-4) outputs per frame. Non-interior accepted pixels update counters only.
- Config latch: op and se_sel are sampled on the in_valid cycle with row=0, col=0 and held for the whole frame. Changes mid-frame have no effect until the next frame start.
- Masking: taps outside the selected element are replaced by the identity value, 8'hFF for erode and 8'h00 for dilate.
- Reduction: min/max over all 25 masked taps. Values are unsigned 8-bit; there is no arithmetic widening.
- Boundary flags are computed from the counters for the interior window and travel with the data:
  - out_sof: row=4, col=4
  - out_eol: col=IMG_W-1
  - out_eof: row=IMG_H-1, col=IMG_W-1
- There is no backpressure. Every interior in_valid yields exactly one out_valid.

## Timing
- Pipeline of 3 registered stages:
  - S1: mask the taps.
  - S2: reduce each of the 5 rows to one value.
  - S3: reduce the 5 row results to one value.
- Latency: out_valid rises exactly 3 cycles after the qualifying in_valid.
- in_valid may be deasserted on any cycle. The resulting bubbles propagate unchanged, with no reordering or drops.
- Flags are aligned with out_valid and are 0 whenever out_valid=0.
- Reset values:
  - out_valid, out_sof, out_eol, out_eof = 0
  - out_pix = 0
  - col = row = 0
  - latched op = 0, latched se_sel = 00
  - all pipeline valid bits = 0
- Reset mid-frame: all in-flight results are discarded, with no partial outputs after release. The first in_valid after release is treated as (0,0) and latches the config.
- An in_valid coincident with the counter wrap is handled normally. The frame-start latch applies to that pixel's successor frame position only when that position is (0,0).

## Structure
- Shared package `morph_pkg` holds:
  - op encodings: OP_ERODE, OP_DILATE
  - se_sel encodings: SE_SQ5, SE_CROSS5, SE_SQ3, SE_DIAMOND
  - 25-bit tap mask constants, one per element
  - identity constants: MIN_ID = 8'hFF, MAX_ID = 8'h00
- One sub-module, `morph_reduce5`: a combinational 5-input min/max selected by op. It is instantiated 5× in S2 and 1× in S3.

## Test plan
All scenarios run with IMG_W=IMG_H=8.
- Constant frame, all pixels 100, erode square5, in_valid every cycle:
  - exactly 16 outputs, all 100
  - out_sof on output 1, out_eol on outputs 4/8/12/16, out_eof on output 16
  - first output 3 cycles after the pixel at (4,4)
- Dilate, taps 0 except one 255:
  - at w0: square5 → 255, cross5 → 0, diamond → 0
  - at w2: diamond → 255
  - at w6: square3 → 255
- Erode, taps 200 except one 0:
  - at w6: square3 → 0
  - at w0: square3 → 200
  - at w10: cross5 → 0
- Config latch: start a frame with op=0 and switch to op=1 at row 5.
  - the rest of that frame stays erode
  - the next frame, started with op=1, dilates
- Bubbles: alternate in_valid 1/0 over the frame.
  - 16 outputs, each exactly 3 cycles after its input
  - flags are correct and there are no spurious out_valid
- Reset mid-frame: pull rst_n low for 1 cycle at row 5.
  - outputs go to 0 immediately and no stale results follow
  - after release, a full frame produces 16 correct outputs starting from (0,0)

Source files
------------

// File: rtl/morph_pkg.sv
// morph_pkg: shared encodings and helpers for the 5x5 min/max morphology stage.
//   - op encodings (erode = min, dilate = max)
//   - structuring-element encodings and their 25-bit tap masks
//     (bit N of a mask selects tap wN, row N/5, col N%5, centre w12)
//   - identity values that make a masked-out tap transparent to the reduction
package morph_pkg;

  typedef enum logic {
    OP_ERODE  = 1'b0,
    OP_DILATE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    SE_SQ5     = 2'b00,
    SE_CROSS5  = 2'b01,
    SE_SQ3     = 2'b10,
    SE_DIAMOND = 2'b11
  } se_e;

  // All 25 taps.
  localparam logic [24:0] MASK_SQ5     = 25'h1FF_FFFF;
  // Centre row (taps 10..14) and centre column (taps 2,7,12,17,22).
  localparam logic [24:0] MASK_CROSS5  = 25'h042_7C84;
  // Inner 3x3: taps 6-8, 11-13, 16-18.
  localparam logic [24:0] MASK_SQ3     = 25'h007_39C0;
  // Manhattan distance <= 2 from the centre: 13 taps.
  localparam logic [24:0] MASK_DIAMOND = 25'h047_7DC4;

  localparam logic [7:0] MIN_ID = 8'hFF;
  localparam logic [7:0] MAX_ID = 8'h00;

  // Flags that travel alongside each result through the pipeline.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } flags_t;

  function automatic logic [24:0] se_mask(input se_e sel);
    logic [24:0] m;
    case (sel)
      SE_SQ5:     m = MASK_SQ5;
      SE_CROSS5:  m = MASK_CROSS5;
      SE_SQ3:     m = MASK_SQ3;
      SE_DIAMOND: m = MASK_DIAMOND;
      default:    m = MASK_SQ5;
    endcase
    return m;
  endfunction

  // Value that never wins the reduction for the given operation.
  function automatic logic [7:0] ident(input op_e op);
    return (op == OP_DILATE) ? MAX_ID : MIN_ID;
  endfunction

endpackage

// File: rtl/morph_5x5_minmax_reduce5.sv
// morph_reduce5: combinational 5-input unsigned min (erode) / max (dilate).
//   op_i  : OP_ERODE selects minimum, OP_DILATE selects maximum
//   in_i  : five 8-bit operands
//   res_o : reduction result
module morph_reduce5
  import morph_pkg::*;
(
  input  op_e              op_i,
  input  logic [4:0][7:0]  in_i,
  output logic [7:0]       res_o
);

  logic [7:0] acc_s;

  // Linear compare chain; ternaries keep every path assigned.
  always_comb begin
    acc_s = in_i[0];
    for (int i = 1; i < 5; i++) begin
      acc_s = (op_i == OP_DILATE) ? ((in_i[i] > acc_s) ? in_i[i] : acc_s)
                                  : ((in_i[i] < acc_s) ? in_i[i] : acc_s);
    end
    res_o = acc_s;
  end

endmodule

// File: rtl/morph_5x5_minmax.sv
// morph_5x5_minmax: 3-stage grey-scale erosion/dilation over a 5x5 window.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   in_valid_i   : win_i holds the window of a newly accepted pixel
//   win_i        : taps w0..w24, wN at [8N+7:8N]; w24 is the newest pixel
//   op_i         : 0 erode (min), 1 dilate (max); latched at frame start
//   se_sel_i     : structuring element; latched at frame start
//   out_valid_o  : out_pix_o holds a result (3 cycles after its input)
//   out_pix_o    : morphology result
//   out_sof_o / out_eol_o / out_eof_o : first of frame / last of row / last of frame
// Only fully interior windows (row>=4, col>=4 of the newest pixel) yield output.
module morph_5x5_minmax
  import morph_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [199:0] win_i,
  input  logic         op_i,
  input  logic [1:0]   se_sel_i,
  output logic         out_valid_o,
  output logic [7:0]   out_pix_o,
  output logic         out_sof_o,
  output logic         out_eol_o,
  output logic         out_eof_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_INNER = CW'(4);
  localparam logic [RW-1:0] ROW_INNER = RW'(4);

  // Position of the newest pixel and frame configuration.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  op_e           cfg_op_q, cfg_op_d;
  se_e           cfg_se_q, cfg_se_d;

  // Stage-1 inputs (combinational).
  logic              interior_s;
  flags_t            flags_s;
  logic [24:0]       mask_s;
  logic [7:0]        id_s;
  logic [24:0][7:0]  taps_d;

  // Pipeline registers. op travels with the data so a frame-start latch
  // never alters results of the previous frame still in flight.
  logic              s1_vld_q;
  logic [24:0][7:0]  s1_taps_q;
  op_e               s1_op_q;
  flags_t            s1_flg_q;

  logic [4:0][7:0]   row_red_s;
  logic              s2_vld_q;
  logic [4:0][7:0]   s2_rows_q;
  op_e               s2_op_q;
  flags_t            s2_flg_q;

  logic [7:0]        final_s;
  logic              out_valid_q;
  logic [7:0]        out_pix_q;
  flags_t            out_flg_q;

  // Counter advance and frame-start configuration capture.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    cfg_op_d = cfg_op_q;
    cfg_se_d = cfg_se_q;
    if (in_valid_i) begin
      if (col_q == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
      if ((col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}})) begin
        cfg_op_d = op_e'(op_i);
        cfg_se_d = se_e'(se_sel_i);
      end else begin
        cfg_op_d = cfg_op_q;
        cfg_se_d = cfg_se_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position and configuration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= {CW{1'b0}};
      row_q    <= {RW{1'b0}};
      cfg_op_q <= OP_ERODE;
      cfg_se_q <= SE_SQ5;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      cfg_op_q <= cfg_op_d;
      cfg_se_q <= cfg_se_d;
    end
  end

  // Interior test, boundary flags and tap masking for stage 1.
  always_comb begin
    interior_s  = (row_q >= ROW_INNER) && (col_q >= COL_INNER);
    flags_s.sof = (row_q == ROW_INNER) && (col_q == COL_INNER);
    flags_s.eol = (col_q == COL_LAST);
    flags_s.eof = (row_q == ROW_LAST) && (col_q == COL_LAST);
    mask_s      = se_mask(cfg_se_q);
    id_s        = ident(cfg_op_q);
    for (int n = 0; n < 25; n++) begin
      taps_d[n] = mask_s[n] ? win_i[8*n +: 8] : id_s;
    end
  end

  // Stage 1: masked taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_taps_q <= '{default: 8'h00};
      s1_op_q   <= OP_ERODE;
      s1_flg_q  <= 3'b000;
    end else begin
      s1_vld_q <= in_valid_i && interior_s;
      if (in_valid_i && interior_s) begin
        s1_taps_q <= taps_d;
        s1_op_q   <= cfg_op_q;
        s1_flg_q  <= flags_s;
      end else begin
        s1_taps_q <= s1_taps_q;
        s1_op_q   <= s1_op_q;
        s1_flg_q  <= s1_flg_q;
      end
    end
  end

  // One reducer per window row (row r holds taps 5r..5r+4).
  for (genvar r = 0; r < 5; r++) begin : g_row
    morph_reduce5 u_row_red (
      .op_i  (s1_op_q),
      .in_i  (s1_taps_q[5*r +: 5]),
      .res_o (row_red_s[r])
    );
  end

  // Stage 2: per-row results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_rows_q <= '{default: 8'h00};
      s2_op_q   <= OP_ERODE;
      s2_flg_q  <= 3'b000;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_rows_q <= row_red_s;
        s2_op_q   <= s1_op_q;
        s2_flg_q  <= s1_flg_q;
      end else begin
        s2_rows_q <= s2_rows_q;
        s2_op_q   <= s2_op_q;
        s2_flg_q  <= s2_flg_q;
      end
    end
  end

  morph_reduce5 u_final_red (
    .op_i  (s2_op_q),
    .in_i  (s2_rows_q),
    .res_o (final_s)
  );

  // Stage 3: output register; flags forced low on bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= 8'h00;
      out_flg_q   <= 3'b000;
    end else begin
      out_valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_pix_q <= final_s;
        out_flg_q <= s2_flg_q;
      end else begin
        out_pix_q <= out_pix_q;
        out_flg_q <= 3'b000;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pix_o   = out_pix_q;
  assign out_sof_o   = out_flg_q.sof;
  assign out_eol_o   = out_flg_q.eol;
  assign out_eof_o   = out_flg_q.eof;

endmodule

// File: tb/tb_morph_5x5_minmax.sv
// Self-checking bench for morph_5x5_minmax on an 8x8 image.
// Expected results come from a tap-membership reference (row/col geometry
// of each structuring element) or from literal values for directed patterns.
module tb_morph_5x5_minmax;

  localparam int W = 8;
  localparam int H = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [199:0] win;
  logic         op;
  logic [1:0]   se;
  logic         out_valid;
  logic [7:0]   out_pix;
  logic         out_sof, out_eol, out_eof;

  typedef struct {
    logic       v;
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   nout  = 0;
  logic       lop;
  logic [1:0] lse;

  morph_5x5_minmax #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .win_i       (win),
    .op_i        (op),
    .se_sel_i    (se),
    .out_valid_o (out_valid),
    .out_pix_o   (out_pix),
    .out_sof_o   (out_sof),
    .out_eol_o   (out_eol),
    .out_eof_o   (out_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_morph(input logic o, input logic [1:0] s, input logic [199:0] w);
    int acc, r, c, v, dr, dc;
    bit sel;
    acc = o ? 0 : 255;
    for (int n = 0; n < 25; n++) begin
      r  = n / 5;
      c  = n % 5;
      dr = (r > 2) ? r - 2 : 2 - r;
      dc = (c > 2) ? c - 2 : 2 - c;
      case (s)
        2'b00:   sel = 1'b1;
        2'b01:   sel = (r == 2) || (c == 2);
        2'b10:   sel = (dr <= 1) && (dc <= 1);
        default: sel = (dr + dc) <= 2;
      endcase
      if (sel) begin
        v   = int'(w[8*n +: 8]);
        acc = o ? ((v > acc) ? v : acc) : ((v < acc) ? v : acc);
      end
    end
    return acc[7:0];
  endfunction

  function automatic logic [199:0] rand_win();
    logic [199:0] w;
    for (int n = 0; n < 25; n++) w[8*n +: 8] = 8'($urandom);
    return w;
  endfunction

  function automatic exp_t no_out();
    exp_t e;
    e.v = 1'b0; e.pix = 8'h00; e.sof = 1'b0; e.eol = 1'b0; e.eof = 1'b0;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {7'b0, out_valid}, 8'h00);
    chk({tag, "_pix"},   out_pix, 8'h00);
    chk({tag, "_flags"}, {5'b0, out_sof, out_eol, out_eof}, 8'h00);
  endtask

  // One clock: drive inputs, advance, compare the output due from 3 cycles earlier.
  task automatic step(input logic v, input logic [199:0] w, input logic o,
                      input logic [1:0] s, input exp_t e);
    exp_t g;
    in_valid = v; win = w; op = o; se = s;
    expq.push_back(e);
    @(posedge clk); #1;
    g = expq.pop_front();
    if (out_valid === 1'b1) nout++;
    chk("out_valid", {7'b0, out_valid}, {7'b0, g.v});
    if (g.v) begin
      chk("out_pix", out_pix, g.pix);
      chk("out_sof", {7'b0, out_sof}, {7'b0, g.sof});
      chk("out_eol", {7'b0, out_eol}, {7'b0, g.eol});
      chk("out_eof", {7'b0, out_eof}, {7'b0, g.eof});
    end else begin
      chk("idle_flags", {5'b0, out_sof, out_eol, out_eof}, 8'h00);
    end
  endtask

  task automatic idle();
    step(1'b0, rand_win(), 1'($urandom), 2'($urandom), no_out());
  endtask

  // mode 0: random taps; mode 1: bg everywhere with tap 'tap' set to tapv.
  // bub 0: none, 1: alternate, 2: random gaps. sw_row: op input inverts from that row.
  // rst_row: pulse reset at (rst_row,0) and abandon the frame.
  task automatic run_frame(input logic op0, input logic [1:0] se0, input int mode,
                           input logic [7:0] bg, input int tap, input logic [7:0] tapv,
                           input logic uselit, input logic [7:0] lit,
                           input int bub, input int sw_row, input int rst_row);
    int start;
    logic [199:0] w;
    logic o;
    exp_t e;
    start = nout;
    for (int p = 0; p < W * H; p++) begin
      int r, c;
      r = p / W;
      c = p % W;
      if (r == rst_row && c == 0) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_now");
        @(posedge clk); #1;
        chk_zero("rst_hold");
        rst_n = 1'b1;
        expq.delete();
        expq.push_back(no_out());
        expq.push_back(no_out());
        return;
      end
      if (bub == 2) begin
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) idle();
      end
      if (mode == 0) begin
        w = rand_win();
      end else begin
        for (int n = 0; n < 25; n++) w[8*n +: 8] = bg;
        if (tap >= 0) w[8*tap +: 8] = tapv;
      end
      o = (r >= sw_row) ? ~op0 : op0;
      if (r == 0 && c == 0) begin
        lop = o;
        lse = se0;
      end
      e.v   = (r >= 4) && (c >= 4);
      e.pix = uselit ? lit : ref_morph(lop, lse, w);
      e.sof = (r == 4) && (c == 4);
      e.eol = (c == W - 1);
      e.eof = (r == H - 1) && (c == W - 1);
      step(1'b1, w, o, se0, e);
      if (bub == 1) idle();
    end
    repeat (3) idle();
    chk("frame_outputs", 8'(nout - start), 8'd16);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; win = '0; op = 1'b0; se = 2'b00;
    lop = 1'b0; lse = 2'b00;
    expq.push_back(no_out());
    expq.push_back(no_out());
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Constant frame, erode square5.
    run_frame(1'b0, 2'b00, 1, 8'd100, -1, 8'd0, 1'b1, 8'd100, 0, 99, 99);
    // Dilate, background 0 with a single 255.
    run_frame(1'b1, 2'b00, 1, 8'd0, 0, 8'd255, 1'b1, 8'd255, 0, 99, 99);
    run_frame(1'b1, 2'b01, 1, 8'd0, 0, 8'd255, 1'b1, 8'd0,   0, 99, 99);
    run_frame(1'b1, 2'b11, 1, 8'd0, 0, 8'd255, 1'b1, 8'd0,   0, 99, 99);
    run_frame(1'b1, 2'b11, 1, 8'd0, 2, 8'd255, 1'b1, 8'd255, 0, 99, 99);
    run_frame(1'b1, 2'b10, 1, 8'd0, 6, 8'd255, 1'b1, 8'd255, 0, 99, 99);
    // Erode, background 200 with a single 0.
    run_frame(1'b0, 2'b10, 1, 8'd200, 6,  8'd0, 1'b1, 8'd0,   0, 99, 99);
    run_frame(1'b0, 2'b10, 1, 8'd200, 0,  8'd0, 1'b1, 8'd200, 0, 99, 99);
    run_frame(1'b0, 2'b01, 1, 8'd200, 10, 8'd0, 1'b1, 8'd0,   0, 99, 99);
    // Random windows, every element, random gaps.
    for (int k = 0; k < 4; k++) begin
      run_frame(1'($urandom), 2'(k), 0, 8'd0, -1, 8'd0, 1'b0, 8'd0, 2, 99, 99);
    end
    // Config latch: op input flips at row 5 but the frame stays erode.
    run_frame(1'b0, 2'b00, 0, 8'd0, -1, 8'd0, 1'b0, 8'd0, 0, 5, 99);
    run_frame(1'b1, 2'b00, 0, 8'd0, -1, 8'd0, 1'b0, 8'd0, 0, 99, 99);
    // Alternating bubbles.
    run_frame(1'b0, 2'b10, 0, 8'd0, -1, 8'd0, 1'b0, 8'd0, 1, 99, 99);
    // Reset at row 5, then a clean frame from (0,0).
    run_frame(1'b1, 2'b11, 0, 8'd0, -1, 8'd0, 1'b0, 8'd0, 0, 99, 5);
    run_frame(1'b0, 2'b01, 0, 8'd0, -1, 8'd0, 1'b0, 8'd0, 0, 99, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
